flag_sched: RTL and testbench

FLAG_SCHED -- requirements
Module: flag_sched

---
 rtl/flag_sched.sv | 91 +++++++++
 tb/tb_flag_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_sched.sv
// Condition-code issue scheduler: stalls flag-dependent instructions
// until in-flight flag setters retire, and tracks the architectural CPSR flags.
module flag_sched #(
  parameter int MAXPEND = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       issuevalidin,
  input  logic [3:0] condin,
  input  logic       setsin,
  input  logic       aluflagsvalidin,
  input  logic [3:0] aluflagsin,
  input  logic       flushin,
  output logic       issuereadyout,
  output logic       execout,
  output logic       skipout,
  output logic [3:0] cpsrout,
  output logic [1:0] pendingout,
  output logic       errout
);

  localparam logic [1:0] MAXP = 2'(MAXPEND);

  logic [3:0] eff;
  logic [2:0] code;
  logic       sel;
  logic       fn, fz, fc, fv;
  logic       base;
  logic       pass;
  logic       dep;
  logic       stall;
  logic       acc;
  logic       ret;
  logic       inc;

  assign code = condin[3:1];
  assign sel  = condin[0];
  assign dep  = (code != 3'b111);

  // A sole in-flight setter returning now forwards its flags directly.
  assign eff = (aluflagsvalidin && pendingout == 2'd1) ?
               aluflagsin : cpsrout;
  assign {fn, fz, fc, fv} = eff;

  always_comb begin
    base = 1'b1;
    unique case (code)
      3'b000: base = fz;
      3'b001: base = fc;
      3'b010: base = fn;
      3'b011: base = fv;
      3'b100: base = fc & ~fz;
      3'b101: base = ~(fn ^ fv);
      3'b110: base = ~fz & ~(fn ^ fv);
      3'b111: base = 1'b1;
    endcase
    pass = (code == 3'b111) ? 1'b1 : (base ^ sel);
  end

  assign stall = issuevalidin & (
      (dep & (pendingout >= 2'd2)) |
      (dep & (pendingout == 2'd1) & ~aluflagsvalidin) |
      (setsin & (pendingout == MAXP) & ~aluflagsvalidin));

  assign issuereadyout = nreset & ~flushin & ~stall;
  assign acc = issuevalidin & issuereadyout;
  assign inc = acc & setsin & pass;
  assign ret = aluflagsvalidin & (pendingout != 2'd0) & ~flushin;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      cpsrout    <= 4'b0000;
      pendingout <= 2'd0;
      execout    <= 1'b0;
      skipout    <= 1'b0;
      errout     <= 1'b0;
    end else begin
      execout <= acc & pass;
      skipout <= acc & ~pass;
      if (flushin)
        pendingout <= 2'd0;
      else
        pendingout <= pendingout + {1'b0, inc} - {1'b0, ret};
      if (ret)
        cpsrout <= aluflagsin;
      if (aluflagsvalidin && pendingout == 2'd0 && !flushin)
        errout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flag_sched.sv
// Randomized bench for flag_sched with a behavioural scoreboard
// plus directed scenarios pinned to hand-computed values.
module tb_flag_sched;

  localparam int MAXPEND = 2;

  logic       clk = 1'b0;
  logic       nreset;
  logic       issuevalidin;
  logic [3:0] condin;
  logic       setsin;
  logic       aluflagsvalidin;
  logic [3:0] aluflagsin;
  logic       flushin;
  logic       issuereadyout;
  logic       execout;
  logic       skipout;
  logic [3:0] cpsrout;
  logic [1:0] pendingout;
  logic       errout;

  int total = 0;
  int bad = 0;

  int       mpend = 0;
  bit [3:0] mcpsr = 4'b0;
  bit       merr = 1'b0;
  bit       mexec = 1'b0;
  bit       mskip = 1'b0;

  always #5 clk = ~clk;

  flag_sched #(.MAXPEND(MAXPEND)) dut (
    .clk(clk),
    .nreset(nreset),
    .issuevalidin(issuevalidin),
    .condin(condin),
    .setsin(setsin),
    .aluflagsvalidin(aluflagsvalidin),
    .aluflagsin(aluflagsin),
    .flushin(flushin),
    .issuereadyout(issuereadyout),
    .execout(execout),
    .skipout(skipout),
    .cpsrout(cpsrout),
    .pendingout(pendingout),
    .errout(errout)
  );

  function automatic bit cpass(bit [3:0] cd, bit [3:0] f);
    bit nn = f[3];
    bit zz = f[2];
    bit cc = f[1];
    bit vv = f[0];
    bit b;
    case (cd[3:1])
      3'd0: b = zz;
      3'd1: b = cc;
      3'd2: b = nn;
      3'd3: b = vv;
      3'd4: b = cc && !zz;
      3'd5: b = (nn == vv);
      3'd6: b = !zz && (nn == vv);
      default: return 1'b1;
    endcase
    return b ^ cd[0];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive, check ready, advance model, check registered outputs.
  task automatic step(input bit rn, input bit v, input bit [3:0] c,
                      input bit s, input bit afv, input bit [3:0] af,
                      input bit fl, output bit rdy);
    bit dep, mrdy, acc, ok, ret;
    bit [3:0] eff;
    nreset = rn;
    issuevalidin = v;
    condin = c;
    setsin = s;
    aluflagsvalidin = afv;
    aluflagsin = af;
    flushin = fl;
    dep = (c[3:1] != 3'b111);
    mrdy = rn && !fl;
    if (v && dep && mpend >= 2) mrdy = 1'b0;
    if (v && dep && mpend == 1 && !afv) mrdy = 1'b0;
    if (v && s && mpend == MAXPEND && !afv) mrdy = 1'b0;
    #1;
    rdy = issuereadyout;
    chk("ready", int'(issuereadyout), int'(mrdy));
    eff = (afv && mpend == 1) ? af : mcpsr;
    ok = cpass(c, eff);
    acc = v && mrdy;
    if (!rn) begin
      mpend = 0; mcpsr = 4'b0; merr = 1'b0;
      mexec = 1'b0; mskip = 1'b0;
    end else if (fl) begin
      mpend = 0; mexec = 1'b0; mskip = 1'b0;
    end else begin
      ret = afv && mpend > 0;
      if (afv && mpend == 0) merr = 1'b1;
      if (ret) begin
        mcpsr = af;
        mpend--;
      end
      if (acc && s && ok) mpend++;
      mexec = acc && ok;
      mskip = acc && !ok;
    end
    @(posedge clk);
    #1;
    chk("exec", int'(execout), int'(mexec));
    chk("skip", int'(skipout), int'(mskip));
    chk("pending", int'(pendingout), mpend);
    chk("cpsr", int'(cpsrout), int'(mcpsr));
    chk("err", int'(errout), int'(merr));
  endtask

  task automatic idle(input bit rn);
    bit r;
    step(rn, 1'b0, 4'b1110, 1'b0, 1'b0, 4'b0, 1'b0, r);
  endtask

  initial begin
    bit r;
    bit v, s, afv, fl, rn;
    bit [3:0] c, af;
    nreset = 1'b0;
    issuevalidin = 1'b0;
    condin = 4'b1110;
    setsin = 1'b0;
    aluflagsvalidin = 1'b0;
    aluflagsin = 4'b0;
    flushin = 1'b0;
    @(posedge clk);
    #1;

    // reset: ready low, outputs cleared
    idle(1'b0);
    chk("rst_ready", int'(r), 0);
    step(1'b0, 1'b1, 4'b1110, 1'b1, 1'b1, 4'b1111, 1'b0, r);
    chk("rst_ready_busy", int'(r), 0);
    chk("rst_cpsr", int'(cpsrout), 0);
    chk("rst_pend", int'(pendingout), 0);
    chk("rst_err", int'(errout), 0);

    // EQ with Z=0 skips
    step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0, 1'b0, r);
    chk("eq_ready", int'(r), 1);
    chk("eq_skip", int'(skipout), 1);
    chk("eq_exec", int'(execout), 0);

    // AL setter then EQ forwarded from returning flags
    step(1'b1, 1'b1, 4'b1110, 1'b1, 1'b0, 4'b0, 1'b0, r);
    chk("al_exec", int'(execout), 1);
    chk("al_pend", int'(pendingout), 1);
    step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0, 1'b0, r);
    chk("eq_stall", int'(r), 0);
    step(1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b0, r);
    chk("eq_fwd_ready", int'(r), 1);
    chk("eq_fwd_exec", int'(execout), 1);
    chk("eq_fwd_cpsr", int'(cpsrout), 4'b0100);

    // two setters, third stalls until a return
    step(1'b1, 1'b1, 4'b1110, 1'b1, 1'b0, 4'b0, 1'b0, r);
    step(1'b1, 1'b1, 4'b1110, 1'b1, 1'b0, 4'b0, 1'b0, r);
    chk("two_pend", int'(pendingout), 2);
    step(1'b1, 1'b1, 4'b1110, 1'b1, 1'b0, 4'b0, 1'b0, r);
    chk("third_stall", int'(r), 0);
    step(1'b1, 1'b1, 4'b1110, 1'b1, 1'b1, 4'b0000, 1'b0, r);
    chk("third_ready", int'(r), 1);
    chk("third_pend", int'(pendingout), 2);

    // GT waits for the second return and uses it
    step(1'b1, 1'b1, 4'b1100, 1'b0, 1'b1, 4'b0100, 1'b0, r);
    chk("gt_stall", int'(r), 0);
    chk("gt_pend1", int'(pendingout), 1);
    step(1'b1, 1'b1, 4'b1100, 1'b0, 1'b1, 4'b0000, 1'b0, r);
    chk("gt_ready", int'(r), 1);
    chk("gt_exec", int'(execout), 1);
    chk("gt_cpsr", int'(cpsrout), 0);

    // flush drops in-flight setters and arriving flags
    step(1'b1, 1'b1, 4'b1110, 1'b1, 1'b0, 4'b0, 1'b0, r);
    step(1'b1, 1'b1, 4'b1110, 1'b1, 1'b0, 4'b0, 1'b0, r);
    step(1'b1, 1'b1, 4'b1110, 1'b1, 1'b1, 4'b1111, 1'b1, r);
    chk("fl_ready", int'(r), 0);
    chk("fl_pend", int'(pendingout), 0);
    chk("fl_cpsr", int'(cpsrout), 0);
    chk("fl_exec", int'(execout), 0);
    chk("fl_err", int'(errout), 0);
    step(1'b1, 1'b0, 4'b1110, 1'b0, 1'b1, 4'b1010, 1'b0, r);
    chk("stray_err", int'(errout), 1);
    chk("stray_cpsr", int'(cpsrout), 0);

    // reset mid-operation
    step(1'b1, 1'b1, 4'b1110, 1'b1, 1'b0, 4'b0, 1'b0, r);
    step(1'b0, 1'b1, 4'b1110, 1'b1, 1'b1, 4'b1111, 1'b0, r);
    chk("mid_rst_pend", int'(pendingout), 0);
    chk("mid_rst_err", int'(errout), 0);
    chk("mid_rst_exec", int'(execout), 0);
    step(1'b1, 1'b0, 4'b1110, 1'b0, 1'b1, 4'b1001, 1'b0, r);
    chk("post_rst_cpsr", int'(cpsrout), 0);
    chk("post_rst_err", int'(errout), 1);
    idle(1'b0);

    for (int i = 0; i < 4000; i++) begin
      rn = ($urandom_range(0, 99) != 0);
      v = $urandom_range(0, 1);
      c = v ? 4'($urandom) : 4'b1110;
      s = v ? 1'($urandom) : 1'b0;
      afv = ($urandom_range(0, 2) == 0);
      af = 4'($urandom);
      fl = ($urandom_range(0, 15) == 0);
      step(rn, v, c, s, afv, af, fl, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
